uart_buffer: RTL and testbench
==============================

# uart_buffer

Byte-buffering stage between the UART transceiver and the pipeline core's peripheral bus. Receive side: captures each received byte, acknowledges the UART receiver, and queues the byte for the core to pop. Transmit side: queues bytes pushed by the core and drains them one at a time into the UART transmitter with a start-pulse handshake. It frees the core from polling the UART at character rate and prevents lost bytes while the core runs on its divided clock.

## Interface
- DEPTH, 8, entries per FIFO; power of two, ≥2
- AW, $clog2(DEPTH), pointer width (derived)
- sysclk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- rx_eff  in  1  UART receiver: byte valid, one-cycle pulse
- rx_data  in  8  UART receiver byte, valid with rx_eff
- rx_read  out  1  acknowledge to UART receiver, one-cycle pulse
- tx_status  in  1  UART transmitter idle (1 = idle)
- tx_en  out  1  transmit start, one-cycle pulse
- tx_data  out  8  byte to transmit; held from tx_en until next tx_en
- rd_req  in  1  core pops RX head, one-cycle strobe
- rd_data  out  8  RX head byte (show-ahead); 8'h00 when empty
- rx_count  out  AW+1  RX occupancy, 0..DEPTH
- rx_overflow  out  1  sticky: RX byte dropped
- clr_ovf  in  1  clears rx_overflow
- wr_req  in  1  core pushes wr_data, one-cycle strobe
- wr_data  in  8  TX byte from core
- tx_count  out  AW+1  TX occupancy, 0..DEPTH
- tx_full  out  1  tx_count == DEPTH

All core-side strobes are synchronous to sysclk and single-cycle; edge-detection from the core clock is done at the top level.

## Operation
- Reset: both FIFOs empty, pointers 0, counts 0; rx_read=0, tx_en=0, tx_data=8'h00, rd_data=8'h00, rx_overflow=0, TX FSM in TX_IDLE.
- RX push: rx_eff while not full → byte written at write pointer; rx_count+1.
- RX push while full → byte dropped, rx_overflow←1. rx_read still pulses so the UART is always released.
- rx_read is registered and asserts exactly one cycle after every sampled rx_eff.
- RX pop: rd_req while non-empty → read pointer advances; rx_count−1. rd_req while empty → ignored.
- Simultaneous rx_eff and rd_req:
  - Full: pop and push both occur; no overflow; count unchanged.
  - Empty: push only.
- clr_ovf and overflow event in the same cycle → overflow wins (flag stays 1).
- TX push: wr_req while not full → enqueue. wr_req while full → ignored, no flag (the core checks tx_full). Simultaneous push and FSM pop are both honoured.
- Pointers are AW bits and wrap DEPTH−1→0. Counts are AW+1 bits and never exceed DEPTH or go below 0.
- TX FSM:
  - TX_IDLE: tx_count>0 and tx_status=1 → TX_START.
  - TX_START: tx_en=1 for one cycle; tx_data←head; pop head; → TX_WAIT_BUSY.
  - TX_WAIT_BUSY: wait for tx_status=0 → TX_WAIT_DONE.
  - TX_WAIT_DONE: wait for tx_status=1 → TX_IDLE.
- Reset mid-transmit: FSM returns to TX_IDLE and TX contents are lost. The next start waits for tx_status=1.

## Timing
- tx_en and rx_read are registered outputs; all other outputs are registered or derived from registered state.
- rx_eff sampled at edge E0: rx_read high in E0→E1; rx_count and rd_data updated after E0.
- rd_req sampled at E0: next head on rd_data after E0.
- Empty TX FIFO, tx_status=1, wr_req sampled at E0: tx_count=1 after E0; state=TX_START after E1; tx_en high E1→E2; tx_count=0 after E2.
- Back-to-back bytes: minimum spacing is START + ≥1 busy cycle + ≥1 idle-detect cycle (4 cycles when tx_status toggles immediately).

## Structure
- Package uart_buffer_pkg: tx_state_t enum {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE}; BYTE_W=8.
- Sub-module byte_fifo (DEPTH parameter, push/pop/full/empty/count, show-ahead head), instantiated twice (RX and TX). Overflow flag, rx_read and the FSM live in uart_buffer.

## Test plan
- Reset with stale traffic → all outputs 0, state TX_IDLE; rd_req on empty leaves rx_count=0.
- RX 0x41, 0x42, 0x43 via rx_eff → three rx_read pulses each one cycle later; rx_count=3; rd_data=0x41; after rd_req, rd_data=0x42.
- RX 9 bytes (DEPTH=8) with no pops → rx_count=8; rx_overflow=1; 9th byte dropped; 9 rx_read pulses. clr_ovf → flag 0.
- Full RX FIFO, rx_eff and rd_req same cycle → rx_count stays 8; overflow stays 0; new byte at tail.
- TX 0x55, 0xAA with a tx_status model (busy 10 cycles after tx_en) → tx_en 2 cycles after first wr_req with tx_data=0x55; second tx_en only after tx_status returns to 1, tx_data=0xAA.
- 9 TX pushes with tx_status held 0 → tx_full=1, tx_count=8, 9th push ignored, no tx_en. Assert reset mid-queue → tx_count=0, tx_en stays 0.

Source files
------------

// File: rtl/uart_buffer_pkg.sv
// Shared types and widths for the UART byte buffer.
package uart_buffer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_buffer_if.sv
// Core/UART-facing signal bundle of the UART byte buffer.
interface uart_buffer_if
  import uart_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              rx_eff;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_read;
  logic              tx_status;
  logic              tx_en;
  logic [BYTE_W-1:0] tx_data;
  logic              rd_req;
  logic [BYTE_W-1:0] rd_data;
  logic [AW:0]       rx_count;
  logic              rx_overflow;
  logic              clr_ovf;
  logic              wr_req;
  logic [BYTE_W-1:0] wr_data;
  logic [AW:0]       tx_count;
  logic              tx_full;

  // Environment side: UART transceiver plus core bus.
  modport master (
    output rx_eff, rx_data, tx_status, rd_req, clr_ovf, wr_req, wr_data,
    input  rx_read, tx_en, tx_data, rd_data, rx_count, rx_overflow, tx_count, tx_full
  );

  // Buffer side.
  modport slave (
    input  rx_eff, rx_data, tx_status, rd_req, clr_ovf, wr_req, wr_data,
    output rx_read, tx_en, tx_data, rd_data, rx_count, rx_overflow, tx_count, tx_full
  );

endinterface

// File: rtl/uart_buffer_byte_fifo.sv
// Show-ahead byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module byte_fifo
  import uart_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_buffer.sv
// RX/TX byte buffering between the UART transceiver and the core bus.
module uart_buffer
  import uart_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         sysclk,
  input  logic         reset,
  uart_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [AW:0]       rx_cnt;
  logic              rx_read_q;
  logic              overflow_q;

  logic [BYTE_W-1:0] tx_head;
  logic              tx_full_w;
  logic              tx_empty;
  logic [AW:0]       tx_cnt;
  logic              tx_pop_c;
  logic              tx_en_q;
  logic [BYTE_W-1:0] tx_data_q;

  tx_state_t state;
  tx_state_t state_next;

  byte_fifo #(.DEPTH(DEPTH)) rx_fifo (
    .clk(sysclk), .rst(reset),
    .push(bus.rx_eff), .push_data(bus.rx_data), .pop(bus.rd_req),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  byte_fifo #(.DEPTH(DEPTH)) tx_fifo (
    .clk(sysclk), .rst(reset),
    .push(bus.wr_req), .push_data(bus.wr_data), .pop(tx_pop_c),
    .head(tx_head), .full(tx_full_w), .empty(tx_empty), .count(tx_cnt)
  );

  // Release the UART receiver one cycle after each byte; sticky drop flag, set beats clear.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_read_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_read_q <= bus.rx_eff;
      if (bus.rx_eff && rx_full && !bus.rd_req) overflow_q <= 1'b1;
      else if (bus.clr_ovf)                     overflow_q <= 1'b0;
    end
  end

  // TX state register; tx_en and tx_data are launched on entry to TX_START.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state   <= state_next;
      tx_en_q <= (state_next == TX_START);
      if (state_next == TX_START) tx_data_q <= tx_head;
    end
  end

  // TX sequencing: start when a byte is queued and the transmitter idles, then track busy/idle.
  always_comb begin
    state_next = state;
    tx_pop_c   = 1'b0;
    case (state)
      TX_IDLE:      if (!tx_empty && bus.tx_status) state_next = TX_START;
      TX_START: begin
        tx_pop_c   = 1'b1;
        state_next = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (!bus.tx_status) state_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (bus.tx_status)  state_next = TX_IDLE;
      default:      state_next = TX_IDLE;
    endcase
  end

  assign bus.rx_read     = rx_read_q;
  assign bus.rd_data     = rx_empty ? '0 : rx_head;
  assign bus.rx_count    = rx_cnt;
  assign bus.rx_overflow = overflow_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_count    = tx_cnt;
  assign bus.tx_full     = tx_full_w;

endmodule

// File: tb/tb_uart_buffer.sv
// Self-checking bench for uart_buffer: directed scenarios plus randomized RX/TX traffic.
module tb_uart_buffer;
  import uart_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  // UART transmitter stand-in: busy for busy_len cycles after each tx_en.
  int busy_cnt;
  int busy_len   = 10;
  bit force_busy = 1'b0;

  always #5 sysclk = ~sysclk;

  uart_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_buffer #(.DEPTH(DEPTH)) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge sysclk or posedge reset) begin
    if (reset)           busy_cnt <= 0;
    else if (bus.tx_en)  busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign bus.tx_status = !force_busy && (busy_cnt == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic idle_inputs();
    bus.rx_eff  = 1'b0;
    bus.rx_data = 8'h00;
    bus.rd_req  = 1'b0;
    bus.clr_ovf = 1'b0;
    bus.wr_req  = 1'b0;
    bus.wr_data = 8'h00;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         ovf_m;
    bit         prev_en;
    int         gap;
    int         guard;

    // ---------------- reset with stale traffic ----------------
    bus.rx_eff  = 1'b1;
    bus.rx_data = 8'hA5;
    bus.rd_req  = 1'b1;
    bus.clr_ovf = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'h3C;
    tick();
    tick();
    check("rst_rx_read",  32'(bus.rx_read), 32'h0);
    check("rst_tx_en",    32'(bus.tx_en), 32'h0);
    check("rst_tx_data",  32'(bus.tx_data), 32'h0);
    check("rst_rd_data",  32'(bus.rd_data), 32'h0);
    check("rst_rx_count", 32'(bus.rx_count), 32'h0);
    check("rst_rx_ovf",   32'(bus.rx_overflow), 32'h0);
    check("rst_tx_count", 32'(bus.tx_count), 32'h0);
    check("rst_tx_full",  32'(bus.tx_full), 32'h0);
    check("rst_state",    32'(dut.state), 32'(TX_IDLE));
    idle_inputs();
    reset = 1'b0;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("empty_pop_count", 32'(bus.rx_count), 32'h0);
    check("empty_pop_data",  32'(bus.rd_data), 32'h0);

    // ---------------- RX 0x41..0x43 ----------------
    bus.rx_eff = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_data = 8'(8'h41 + i);
      tick();
      check("rx3_read", 32'(bus.rx_read), 32'h1);
      check("rx3_count", 32'(bus.rx_count), 32'(i + 1));
    end
    bus.rx_eff = 1'b0;
    tick();
    check("rx3_read_end", 32'(bus.rx_read), 32'h0);
    check("rx3_head", 32'(bus.rd_data), 32'h41);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("rx3_head2", 32'(bus.rd_data), 32'h42);
    check("rx3_count2", 32'(bus.rx_count), 32'h2);
    bus.rd_req = 1'b1;
    tick();
    tick();
    bus.rd_req = 1'b0;
    check("rx3_drained", 32'(bus.rx_count), 32'h0);
    check("rx3_empty_data", 32'(bus.rd_data), 32'h0);

    // ---------------- RX overflow ----------------
    bus.rx_eff = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.rx_data = 8'(8'h10 + i);
      tick();
      check("ovf_read", 32'(bus.rx_read), 32'h1);
      check("ovf_count", 32'(bus.rx_count), 32'((i + 1 > 8) ? 8 : i + 1));
    end
    bus.rx_eff = 1'b0;
    tick();
    check("ovf_read_end", 32'(bus.rx_read), 32'h0);
    check("ovf_flag", 32'(bus.rx_overflow), 32'h1);
    check("ovf_head", 32'(bus.rd_data), 32'h10);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_clear", 32'(bus.rx_overflow), 32'h0);

    // full FIFO: simultaneous push and pop
    bus.rx_eff  = 1'b1;
    bus.rx_data = 8'hEE;
    bus.rd_req  = 1'b1;
    tick();
    idle_inputs();
    check("full_both_count", 32'(bus.rx_count), 32'h8);
    check("full_both_ovf", 32'(bus.rx_overflow), 32'h0);
    check("full_both_head", 32'(bus.rd_data), 32'h11);

    // overflow event beats a same-cycle clear
    bus.rx_eff  = 1'b1;
    bus.rx_data = 8'h77;
    bus.clr_ovf = 1'b1;
    tick();
    idle_inputs();
    check("ovf_vs_clr", 32'(bus.rx_overflow), 32'h1);
    check("ovf_vs_clr_count", 32'(bus.rx_count), 32'h8);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;

    bus.rd_req = 1'b1;
    repeat (7) tick();
    bus.rd_req = 1'b0;
    check("tail_count", 32'(bus.rx_count), 32'h1);
    check("tail_byte", 32'(bus.rd_data), 32'hEE);
    bus.rd_req = 1'b1;
    tick();
    tick();
    bus.rd_req = 1'b0;
    check("rx_drain_count", 32'(bus.rx_count), 32'h0);

    // ---------------- TX 0x55, 0xAA ----------------
    busy_len    = 10;
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'h55;
    tick();
    check("tx_cnt_e0", 32'(bus.tx_count), 32'h1);
    check("tx_en_e0", 32'(bus.tx_en), 32'h0);
    bus.wr_data = 8'hAA;
    tick();
    bus.wr_req = 1'b0;
    check("tx_en_e1", 32'(bus.tx_en), 32'h1);
    check("tx_data_e1", 32'(bus.tx_data), 32'h55);
    check("tx_cnt_e1", 32'(bus.tx_count), 32'h2);
    tick();
    check("tx_en_e2", 32'(bus.tx_en), 32'h0);
    check("tx_cnt_e2", 32'(bus.tx_count), 32'h1);
    gap = 1;
    while (bus.tx_en !== 1'b1 && gap < 40) begin
      tick();
      gap++;
    end
    check("tx_gap", 32'(gap), 32'(busy_len + 3));
    check("tx_data2", 32'(bus.tx_data), 32'hAA);
    repeat (busy_len + 4) tick();
    check("tx_done_count", 32'(bus.tx_count), 32'h0);
    check("tx_done_en", 32'(bus.tx_en), 32'h0);

    // ---------------- TX full, transmitter stuck busy ----------------
    force_busy = 1'b1;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.wr_data = 8'(8'hC0 + i);
      tick();
      check("txfull_no_en", 32'(bus.tx_en), 32'h0);
    end
    bus.wr_req = 1'b0;
    check("txfull_count", 32'(bus.tx_count), 32'h8);
    check("txfull_flag", 32'(bus.tx_full), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("txrst_count", 32'(bus.tx_count), 32'h0);
    check("txrst_full", 32'(bus.tx_full), 32'h0);
    check("txrst_en", 32'(bus.tx_en), 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      check("txrst_quiet", 32'(bus.tx_en), 32'h0);
    end
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'h99;
    tick();
    bus.wr_req = 1'b0;
    check("txrst_push", 32'(bus.tx_count), 32'h1);
    repeat (3) begin
      tick();
      check("txrst_wait_idle", 32'(bus.tx_en), 32'h0);
    end
    force_busy = 1'b0;
    tick();
    check("txrst_start", 32'(bus.tx_en), 32'h1);
    check("txrst_data", 32'(bus.tx_data), 32'h99);
    repeat (busy_len + 4) tick();

    // ---------------- randomized RX traffic vs queue model ----------------
    rxq.delete();
    ovf_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic       e, r, c;
      logic [7:0] d;
      bit         was_full, pop_ok;
      e = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      r = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      bus.rx_eff = e; bus.rx_data = d; bus.rd_req = r; bus.clr_ovf = c;
      tick();
      was_full = (rxq.size() == DEPTH);
      pop_ok   = r && (rxq.size() > 0);
      if (pop_ok) void'(rxq.pop_front());
      if (e && (!was_full || pop_ok)) rxq.push_back(d);
      if (e && was_full && !pop_ok) ovf_m = 1'b1;
      else if (c)                   ovf_m = 1'b0;
      check("rnd_rx_read", 32'(bus.rx_read), 32'(e));
      check("rnd_rx_count", 32'(bus.rx_count), 32'(rxq.size()));
      check("rnd_rd_data", 32'(bus.rd_data), 32'((rxq.size() > 0) ? rxq[0] : 8'h00));
      check("rnd_rx_ovf", 32'(bus.rx_overflow), 32'(ovf_m));
    end
    idle_inputs();

    // ---------------- randomized TX traffic vs scoreboard ----------------
    txq.delete();
    prev_en = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic       w;
      logic [7:0] d;
      w = (txq.size() < DEPTH) && ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      busy_len = $urandom_range(1, 6);
      bus.wr_req = w; bus.wr_data = d;
      tick();
      if (prev_en && txq.size() > 0) void'(txq.pop_front());
      if (w) txq.push_back(d);
      check("rnd_tx_count", 32'(bus.tx_count), 32'(txq.size()));
      check("rnd_tx_full", 32'(bus.tx_full), 32'(txq.size() == DEPTH));
      if (bus.tx_en === 1'b1) begin
        check("rnd_tx_data", 32'(bus.tx_data), 32'((txq.size() > 0) ? txq[0] : 8'hxx));
        check("rnd_tx_pulse", 32'(prev_en), 32'h0);
      end
      prev_en = bus.tx_en;
    end
    bus.wr_req = 1'b0;
    guard = 0;
    while (txq.size() > 0 && guard < 600) begin
      tick();
      if (prev_en && txq.size() > 0) void'(txq.pop_front());
      if (bus.tx_en === 1'b1 && txq.size() > 0)
        check("drain_tx_data", 32'(bus.tx_data), 32'(txq[0]));
      prev_en = bus.tx_en;
      guard++;
    end
    check("drain_tx_count", 32'(bus.tx_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
